drowsiness_detector: RTL and testbench
======================================

Name: drowsiness_detector

Overview:
Single-neuron drowsiness classifier. Once after reset, it initializes an internal weight memory with a deterministic ramp. On each Start it computes a weighted sum of 10 unsigned feature inputs, scales and saturates it into outVal, and classifies the result against a threshold. It keeps running counts of awake (class 0) and drowsy (class 1) decisions. It is the top-level inference block fed by the feature-extraction stage.

Parameters:
N_IN, 10, number of inputs and weights.
DW, 10, input, weight, outVal and counter width.
W0, -20, signed initial weight for index 0.
WSTEP, 5, signed increment per weight index: weight[i] = W0 + i*WSTEP.
SHIFT, 4, arithmetic right shift applied to the accumulator.
THRESH, 256, outVal >= THRESH means class 1.

Ports:
Clock  input  1  rising-edge clock.
Rst  input  1  asynchronous, active-high reset.
Start  input  1  level request to run one inference.
in  input  N_IN x DW (unpacked array [0:N_IN-1])  unsigned feature inputs.
dataRead  output  DW signed  weight currently read from memory during MAC.
data  output  DW signed  weight value written during INIT; holds the last written value.
outVal  output  DW  scaled, saturated classifier output.
count0  output  DW  number of class-0 decisions.
count1  output  DW  number of class-1 decisions.

Behaviour:
- Rst=1 (async): FSM to IDLE; weight memory, accumulator, index, init_done flag and all outputs go to 0. Reset mid-operation aborts everything, and weights are re-initialized on the next run.
- FSM states: IDLE, INIT, MAC, DONE.
- IDLE: if Start=1 and init_done=0, go to INIT; if Start=1 and init_done=1, go to MAC. Clear acc and idx on exit.
- INIT (N_IN cycles): each cycle write weight[idx] = W0+idx*WSTEP, drive data with the same value, and idx++. After idx=N_IN-1, set init_done=1, clear idx, go to MAC.
- MAC (N_IN cycles): dataRead = weight[idx], a combinational read registered to the output. Each cycle acc += $signed({1'b0,in[idx]}) * weight[idx].
  - Product is 21-bit signed; acc is 25-bit signed; no overflow is possible.
  - After the last index, go to DONE.
- DONE (1 cycle):
  - Compute s = acc >>> SHIFT. outVal = 0 if s<0, 2^DW-1 if s>2^DW-1, else s[DW-1:0].
  - If that outVal >= THRESH, count1++; else count0++. Counters wrap modulo 2^DW.
  - Return to IDLE.
- Latency from Start sampled in IDLE to outVal valid:
  - First run: 1+N_IN+N_IN+1 = 22 edges.
  - Later runs: 12 edges.
- Start is ignored outside IDLE. Holding Start high re-runs back-to-back, one classification per 12 cycles after the first.
- in[] is sampled per index during MAC. The bench holds it stable for the whole run.
- outVal, dataRead and data hold their values between runs.

Decomposition:
- Package drowsiness_pkg: state enum (IDLE, INIT, MAC, DONE), DW/N_IN/accumulator width constants, default weight constants.
- One sub-module, weight_init_mem: N_IN x DW signed register file. It has an async-reset clear, a write port (we, waddr, wdata) and a combinational read port (raddr -> rdata).
- FSM, MAC and counters stay in the top.

Test Plan:
1. Reset: assert Rst for 100 ns with Start=0 -> all outputs 0; release, 5 idle cycles -> still 0.
2. All in=200, Start=1 -> during INIT data steps -20,-15,...,25. The MAC sum is 200*25=5000, so at cycle 22 outVal=312 (5000>>>4), count1=1, count0=0.
3. All in=0, Start pulse after step 2 -> INIT is skipped. outVal=0 after 12 cycles, count0=1, count1 unchanged at 1.
4. in[0..3]=1023, others 0 -> acc=-51150 -> outVal=0 (negative clamp), count0 increments.
5. in[9]=1023, others 0 -> acc=25575, s=1598 -> outVal=1023 (saturation), count1 increments.
6. Assert Rst during MAC of a run -> outputs and counters 0 immediately. The next Start re-runs INIT, taking 22 cycles to a result.

Source files
------------

// File: rtl/drowsiness_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the drowsiness classifier.
package drowsiness_pkg;

  localparam int N_IN   = 10;
  localparam int DW     = 10;
  localparam int IDX_W  = 4;
  localparam int PROD_W = 21;
  localparam int ACC_W  = 25;
  localparam int W0     = -20;
  localparam int WSTEP  = 5;
  localparam int SHIFT  = 4;
  localparam int THRESH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic signed [DW-1:0] init_weight(input logic [IDX_W-1:0] i);
    int w;
    w = W0 + int'(i) * WSTEP;
    return w[DW-1:0];
  endfunction

  // Scale the accumulator down, then clamp into the unsigned output range.
  function automatic logic [DW-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s[ACC_W-1])
      return '0;
    else if (|s[ACC_W-2:DW])
      return '1;
    else
      return s[DW-1:0];
  endfunction

endpackage

// File: rtl/weight_init_mem.sv
// Small signed weight register file: async clear, one write port, combinational read.
module weight_init_mem
  import drowsiness_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic signed [DW-1:0] rdata
);

  logic signed [DW-1:0] mem [0:N_IN-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/drowsiness_detector.sv
// Single-neuron drowsiness classifier: one-time weight init, MAC over the features,
// scale/saturate, threshold and per-class decision counters.
module drowsiness_detector
  import drowsiness_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [DW-1:0]        in [0:N_IN-1],
  output logic signed [DW-1:0] dataRead,
  output logic signed [DW-1:0] data,
  output logic [DW-1:0]        outVal,
  output logic [DW-1:0]        count0,
  output logic [DW-1:0]        count1
);

  state_t                    state, state_d;
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic                      init_done;
  logic                      last;
  logic                      we;
  logic signed [DW-1:0]      wdata;
  logic signed [DW-1:0]      rdata;
  logic signed [PROD_W-1:0]  prod;
  logic [DW-1:0]             sat_val;

  weight_init_mem u_mem (
    .clk   (Clock),
    .rst   (Rst),
    .we    (we),
    .waddr (idx),
    .wdata (wdata),
    .raddr (idx),
    .rdata (rdata)
  );

  assign last    = (idx == IDX_W'(N_IN - 1));
  assign wdata   = init_weight(idx);
  assign prod    = $signed({1'b0, in[idx]}) * rdata;
  assign sat_val = scale_sat(acc);

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    we      = 1'b0;
    case (state)
      IDLE: if (Start) state_d = init_done ? MAC : INIT;
      INIT: begin
        we = 1'b1;
        if (last) state_d = MAC;
      end
      MAC:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      idx       <= '0;
      acc       <= '0;
      init_done <= 1'b0;
      dataRead  <= '0;
      data      <= '0;
      outVal    <= '0;
      count0    <= '0;
      count1    <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          acc <= '0;
          idx <= '0;
        end
        INIT: begin
          data <= wdata;
          if (last) begin
            init_done <= 1'b1;
            idx       <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        MAC: begin
          dataRead <= rdata;
          acc      <= acc + ACC_W'(prod);
          idx      <= last ? '0 : idx + 1'b1;
        end
        DONE: begin
          outVal <= sat_val;
          if (sat_val >= DW'(THRESH)) count1 <= count1 + 1'b1;
          else                        count0 <= count0 + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drowsiness_detector.sv
// Scoreboard bench for drowsiness_detector: expected results queued at Start, checked at result time.
module tb_drowsiness_detector;

  logic               Clock;
  logic               Rst;
  logic               Start;
  logic [9:0]         in_v [0:9];
  logic signed [9:0]  dataRead;
  logic signed [9:0]  data;
  logic [9:0]         outVal;
  logic [9:0]         count0;
  logic [9:0]         count1;

  typedef struct {
    logic [9:0] o;
    logic [9:0] c0;
    logic [9:0] c1;
  } exp_t;

  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;
  int   m_c0  = 0;
  int   m_c1  = 0;
  bit   m_init = 0;
  logic [9:0] prev_out = '0;

  drowsiness_detector dut (
    .Clock    (Clock),
    .Rst      (Rst),
    .Start    (Start),
    .in       (in_v),
    .dataRead (dataRead),
    .data     (data),
    .outVal   (outVal),
    .count0   (count0),
    .count1   (count1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic int bw(input int i);
    return -20 + 5 * i;
  endfunction

  function automatic void push_expected();
    int   acc;
    int   s;
    exp_t e;
    acc = 0;
    for (int i = 0; i < 10; i++) acc += int'(in_v[i]) * bw(i);
    s = acc >>> 4;
    if (s < 0)         e.o = 10'd0;
    else if (s > 1023) e.o = 10'd1023;
    else               e.o = 10'(s);
    if (int'(e.o) >= 256) m_c1 = (m_c1 + 1) % 1024;
    else                  m_c0 = (m_c0 + 1) % 1024;
    e.c0 = 10'(m_c0);
    e.c1 = 10'(m_c1);
    exp_q.push_back(e);
  endfunction

  task automatic set_all(input int v);
    for (int i = 0; i < 10; i++) in_v[i] = 10'(v);
  endtask

  // One Start pulse; checks INIT data stream, MAC dataRead stream, latency and result.
  task automatic do_run(input string name);
    int   lat;
    int   mac0;
    bit   first;
    exp_t e;
    first = !m_init;
    lat   = first ? 22 : 12;
    mac0  = first ? 12 : 2;
    push_expected();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int ed = 2; ed <= lat; ed++) begin
      @(posedge Clock); #1;
      if (first && ed <= 11) begin
        total++;
        if (data !== 10'(bw(ed - 2))) begin
          bad++;
          $display("FAIL %s init_data edge=%0d got=%0d want=%0d", name, ed, data, bw(ed - 2));
        end
      end
      if (ed >= mac0 && ed < mac0 + 10) begin
        total++;
        if (dataRead !== 10'(bw(ed - mac0))) begin
          bad++;
          $display("FAIL %s dataRead edge=%0d got=%0d want=%0d", name, ed, dataRead, bw(ed - mac0));
        end
      end
      if (ed == lat - 1) begin
        total++;
        if (outVal !== prev_out) begin
          bad++;
          $display("FAIL %s early_out got=%0d want=%0d", name, outVal, prev_out);
        end
      end
    end
    e = exp_q.pop_front();
    total++;
    if (outVal !== e.o || count0 !== e.c0 || count1 !== e.c1) begin
      bad++;
      $display("FAIL %s result got out=%0d c0=%0d c1=%0d want out=%0d c0=%0d c1=%0d",
               name, outVal, count0, count1, e.o, e.c0, e.c1);
    end
    prev_out = e.o;
    m_init   = 1'b1;
  endtask

  task automatic test_reset();
    Rst   = 1'b1;
    Start = 1'b0;
    set_all(0);
    #100;
    total++;
    if (outVal !== 0 || count0 !== 0 || count1 !== 0 || data !== 0 || dataRead !== 0) begin
      bad++;
      $display("FAIL reset_hold got out=%0d c0=%0d c1=%0d data=%0d rd=%0d want all 0",
               outVal, count0, count1, data, dataRead);
    end
    @(negedge Clock);
    Rst = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    total++;
    if (outVal !== 0 || count0 !== 0 || count1 !== 0 || data !== 0 || dataRead !== 0) begin
      bad++;
      $display("FAIL reset_idle got out=%0d c0=%0d c1=%0d data=%0d rd=%0d want all 0",
               outVal, count0, count1, data, dataRead);
    end
  endtask

  task automatic test_first_run();
    set_all(200);
    do_run("first_run");
  endtask

  task automatic test_skip_init();
    set_all(0);
    do_run("skip_init");
  endtask

  task automatic test_neg_clamp();
    set_all(0);
    for (int i = 0; i < 4; i++) in_v[i] = 10'd1023;
    do_run("neg_clamp");
  endtask

  task automatic test_saturation();
    set_all(0);
    in_v[9] = 10'd1023;
    do_run("saturation");
  endtask

  task automatic test_threshold();
    set_all(0);
    in_v[8] = 10'd204;
    do_run("thresh_255");
    set_all(0);
    in_v[9] = 10'd164;
    do_run("thresh_256");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    set_all(164);
    push_expected();
    push_expected();
    Start = 1'b1;
    for (int ed = 1; ed <= 24; ed++) begin
      @(posedge Clock); #1;
      if (ed == 11 || ed == 23) begin
        total++;
        if (outVal !== prev_out) begin
          bad++;
          $display("FAIL b2b early_out edge=%0d got=%0d want=%0d", ed, outVal, prev_out);
        end
      end
      if (ed == 12 || ed == 24) begin
        e = exp_q.pop_front();
        total++;
        if (outVal !== e.o || count0 !== e.c0 || count1 !== e.c1) begin
          bad++;
          $display("FAIL b2b result edge=%0d got out=%0d c0=%0d c1=%0d want out=%0d c0=%0d c1=%0d",
                   ed, outVal, count0, count1, e.o, e.c0, e.c1);
        end
        prev_out = e.o;
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset_mid_mac();
    set_all(100);
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    Rst = 1'b1;
    #1;
    total++;
    if (outVal !== 0 || count0 !== 0 || count1 !== 0 || data !== 0 || dataRead !== 0) begin
      bad++;
      $display("FAIL mid_mac_reset got out=%0d c0=%0d c1=%0d data=%0d rd=%0d want all 0",
               outVal, count0, count1, data, dataRead);
    end
    m_c0     = 0;
    m_c1     = 0;
    m_init   = 1'b0;
    prev_out = '0;
    exp_q.delete();
    @(negedge Clock);
    Rst = 1'b0;
    @(posedge Clock); #1;
    set_all(200);
    do_run("rerun_after_reset");
  endtask

  initial begin
    set_all(0);
    Rst   = 1'b1;
    Start = 1'b0;
    test_reset();
    test_first_run();
    test_skip_init();
    test_neg_clamp();
    test_saturation();
    test_threshold();
    test_back_to_back();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
